// File: rtl/ram_pkg.sv
// ram_pkg: shared widths, halt marker and core id type for the 4-core RAM write path
package ram_pkg;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int NCORE = 4;
    localparam logic [15:0] HALT_WORD = 16'hFFFF;
    typedef logic [1:0] core_id_t;
endpackage

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: picks the first requester at or after ptr, wrapping mod 4
module rr_arbiter4
    import ram_pkg::*;
(
    input  logic [3:0] req,
    input  core_id_t   ptr,
    output logic       gnt_valid,
    output core_id_t   gnt_id
);
    logic [3:0] rot;
    core_id_t   off;
    // rot[k] is the request of core (ptr + k) mod 4
    assign rot = 4'({req, req} >> ptr);
    assign off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
    assign gnt_valid = |req;
    assign gnt_id = ptr + off;
endmodule

// File: rtl/ram_write_arbiter_4core.sv
// ram_write_arbiter_4core: one-entry store buffer per core, serialised round-robin onto one
// registered RAM write port, with sticky per-core detection of the halt word
module ram_write_arbiter_4core
    import ram_pkg::*;
#(
    parameter int ADDR_W = ram_pkg::ADDR_W,
    parameter int DATA_W = ram_pkg::DATA_W,
    parameter logic [DATA_W-1:0] HALT_WORD = ram_pkg::HALT_WORD
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic [NCORE-1:0]        in_valid,
    input  logic [NCORE*ADDR_W-1:0] in_addr,
    input  logic [NCORE*DATA_W-1:0] in_data,
    output logic [NCORE-1:0]        in_ready,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    output core_id_t                mem_src,
    input  logic                    mem_ready,
    output logic [NCORE-1:0]        halt_seen
);
    logic [NCORE-1:0]  full;
    logic [ADDR_W-1:0] buf_addr [NCORE];
    logic [DATA_W-1:0] buf_data [NCORE];
    core_id_t          rr_ptr;
    core_id_t          gnt_id;
    logic              gnt_valid;
    logic              load;

    rr_arbiter4 u_arb (.req(full), .ptr(rr_ptr), .gnt_valid(gnt_valid), .gnt_id(gnt_id));

    assign load = ~mem_we | mem_ready;
    assign in_ready = ~full;

    // payload needs no reset: it is only read while its full bit is set
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCORE; i++)
            if (in_valid[i] && in_ready[i]) begin
                buf_addr[i] <= in_addr[i*ADDR_W +: ADDR_W];
                buf_data[i] <= in_data[i*DATA_W +: DATA_W];
            end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= '0;
            rr_ptr <= '0;
            mem_we <= 1'b0;
            mem_addr <= '0;
            mem_wdata <= '0;
            mem_src <= '0;
            halt_seen <= '0;
        end else if (clear) begin
            full <= '0;
            rr_ptr <= '0;
            mem_we <= 1'b0;
            mem_addr <= '0;
            mem_wdata <= '0;
            mem_src <= '0;
            halt_seen <= '0;
        end else begin
            for (int i = 0; i < NCORE; i++)
                if (in_valid[i] && !full[i]) full[i] <= 1'b1;
            if (load) begin
                mem_we <= gnt_valid;
                if (gnt_valid) begin
                    mem_addr <= buf_addr[gnt_id];
                    mem_wdata <= buf_data[gnt_id];
                    mem_src <= gnt_id;
                    full[gnt_id] <= 1'b0;
                    rr_ptr <= gnt_id + 2'd1;
                    if (buf_data[gnt_id] == HALT_WORD) halt_seen[gnt_id] <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_ram_write_arbiter_4core.sv
// tb_ram_write_arbiter_4core: vector table, corner sequences and random traffic against
// a behavioural model of the store buffers and round-robin write port
module tb_ram_write_arbiter_4core;
    import ram_pkg::*;

    logic        clk = 0, rst_n = 0, clear = 0, mem_ready = 1;
    logic [3:0]  in_valid = 0;
    logic [63:0] in_addr = 0, in_data = 0;
    logic [3:0]  in_ready, halt_seen;
    logic        mem_we;
    logic [15:0] mem_addr, mem_wdata;
    core_id_t    mem_src;
    int          n_chk = 0, n_fail = 0;

    ram_write_arbiter_4core dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_addr(in_addr),
        .in_data(in_data), .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_src(mem_src), .mem_ready(mem_ready), .halt_seen(halt_seen)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    bit          m_full [4];
    logic [15:0] m_addr [4], m_data [4];
    int          m_rr, m_src;
    bit          m_we;
    logic [15:0] m_a, m_d;
    logic [3:0]  m_halt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_full[i] = 0;
        m_rr = 0; m_src = 0; m_we = 0; m_a = 0; m_d = 0; m_halt = 0;
    endtask

    task automatic model_edge();
        bit f0 [4];
        int g;
        if (!rst_n || clear) begin
            model_reset();
            return;
        end
        f0 = m_full;
        g = -1;
        if (!m_we || mem_ready) begin
            for (int k = 0; k < 4; k++)
                if (g < 0 && f0[(m_rr + k) % 4]) g = (m_rr + k) % 4;
            m_we = (g >= 0);
            if (g >= 0) begin
                m_a = m_addr[g];
                m_d = m_data[g];
                m_src = g;
                m_full[g] = 0;
                m_rr = (g + 1) % 4;
                if (m_data[g] == 16'hFFFF) m_halt[g] = 1;
            end
        end
        for (int i = 0; i < 4; i++)
            if (in_valid[i] && !f0[i]) begin
                m_full[i] = 1;
                m_addr[i] = in_addr[i*16 +: 16];
                m_data[i] = in_data[i*16 +: 16];
            end
    endtask

    task automatic model_check();
        logic [3:0] er;
        for (int i = 0; i < 4; i++) er[i] = !m_full[i];
        chk("model in_ready", in_ready, er);
        chk("model mem_we", mem_we, m_we);
        chk("model mem_addr", mem_addr, m_a);
        chk("model mem_wdata", mem_wdata, m_d);
        chk("model mem_src", mem_src, m_src);
        chk("model halt_seen", halt_seen, m_halt);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        model_check();
    endtask

    // entered at a falling edge; reset is asserted mid-phase so the check is asynchronous
    task automatic reset_dut(input string tag);
        #2;
        rst_n = 0; in_valid = 0; clear = 0; mem_ready = 1;
        #1;
        chk({tag, " async in_ready"}, in_ready, 4'hF);
        chk({tag, " async mem_we"}, mem_we, 0);
        chk({tag, " async mem_addr"}, mem_addr, 0);
        chk({tag, " async halt_seen"}, halt_seen, 0);
        model_reset();
        cyc();
        rst_n = 1;
    endtask

    typedef struct {
        logic [3:0]  v;
        logic [63:0] a, d;
        logic [3:0]  rdy;
        logic        we;
        logic [1:0]  src;
        logic [15:0] ma, md;
    } vec_t;
    vec_t tv [16];

    initial begin
        tv[0]  = '{4'b1111, 64'h0103_0102_0101_0100, 64'hA003_A002_A001_A000, 4'b0000, 0, 0, 16'h0000, 16'h0000};
        tv[1]  = '{4'b0000, 64'h0, 64'h0, 4'b0001, 1, 0, 16'h0100, 16'hA000};
        tv[2]  = '{4'b0000, 64'h0, 64'h0, 4'b0011, 1, 1, 16'h0101, 16'hA001};
        tv[3]  = '{4'b0000, 64'h0, 64'h0, 4'b0111, 1, 2, 16'h0102, 16'hA002};
        tv[4]  = '{4'b0000, 64'h0, 64'h0, 4'b1111, 1, 3, 16'h0103, 16'hA003};
        tv[5]  = '{4'b0000, 64'h0, 64'h0, 4'b1111, 0, 3, 16'h0103, 16'hA003};
        tv[6]  = '{4'b0010, 64'h0203_0202_0201_0200, 64'hB003_B002_B001_B000, 4'b1101, 0, 3, 16'h0103, 16'hA003};
        tv[7]  = '{4'b0000, 64'h0, 64'h0, 4'b1111, 1, 1, 16'h0201, 16'hB001};
        tv[8]  = '{4'b1111, 64'h0303_0302_0301_0300, 64'hC003_C002_C001_C000, 4'b0000, 0, 1, 16'h0201, 16'hB001};
        tv[9]  = '{4'b0000, 64'h0, 64'h0, 4'b0100, 1, 2, 16'h0302, 16'hC002};
        tv[10] = '{4'b0000, 64'h0, 64'h0, 4'b1100, 1, 3, 16'h0303, 16'hC003};
        tv[11] = '{4'b0000, 64'h0, 64'h0, 4'b1101, 1, 0, 16'h0300, 16'hC000};
        tv[12] = '{4'b0000, 64'h0, 64'h0, 4'b1111, 1, 1, 16'h0301, 16'hC001};
        tv[13] = '{4'b0100, 64'h0000_0040_0000_0000, 64'h0000_1234_0000_0000, 4'b1011, 0, 1, 16'h0301, 16'hC001};
        tv[14] = '{4'b0000, 64'h0, 64'h0, 4'b1111, 1, 2, 16'h0040, 16'h1234};
        tv[15] = '{4'b0000, 64'h0, 64'h0, 4'b1111, 0, 2, 16'h0040, 16'h1234};

        model_reset();
        @(negedge clk);
        reset_dut("init");
        chk("reset mem_src", mem_src, 0);
        chk("reset mem_wdata", mem_wdata, 0);

        for (int r = 0; r < 16; r++) begin
            in_valid = tv[r].v; in_addr = tv[r].a; in_data = tv[r].d;
            cyc();
            chk($sformatf("row%0d in_ready", r), in_ready, tv[r].rdy);
            chk($sformatf("row%0d mem_we", r), mem_we, tv[r].we);
            chk($sformatf("row%0d mem_src", r), mem_src, tv[r].src);
            chk($sformatf("row%0d mem_addr", r), mem_addr, tv[r].ma);
            chk($sformatf("row%0d mem_wdata", r), mem_wdata, tv[r].md);
        end

        reset_dut("bp");
        in_valid = 4'b1110; in_addr = 64'h0403_0402_0401_0400; in_data = 64'hD003_D002_D001_D000;
        cyc();
        in_valid = 0;
        cyc();
        chk("bp first src", mem_src, 1);
        mem_ready = 0;
        repeat (3) begin
            cyc();
            chk("bp hold we", mem_we, 1);
            chk("bp hold src", mem_src, 1);
            chk("bp hold addr", mem_addr, 16'h0401);
            chk("bp hold data", mem_wdata, 16'hD001);
            chk("bp hold in_ready", in_ready, 4'b0011);
        end
        mem_ready = 1;
        cyc();
        chk("bp next src", mem_src, 2);
        chk("bp next data", mem_wdata, 16'hD002);

        reset_dut("halt");
        in_valid = 4'b1001; in_addr = 64'h0503_0000_0000_0500; in_data = 64'hFFFF_0000_0000_FFFE;
        cyc();
        in_valid = 0;
        repeat (3) cyc();
        chk("halt_seen", halt_seen, 4'b1000);

        reset_dut("clear");
        in_valid = 4'hF; in_addr = 64'h0603_0602_0601_0600; in_data = 64'hE003_E002_E001_E000;
        cyc();
        in_valid = 0;
        cyc();
        chk("clr pre we", mem_we, 1);
        chk("clr pre in_ready", in_ready, 4'b0001);
        clear = 1; mem_ready = 0; in_valid = 4'b0001; in_data = 64'h0000_0000_0000_1111;
        cyc();
        clear = 0; in_valid = 0; mem_ready = 1;
        chk("clr we", mem_we, 0);
        chk("clr in_ready", in_ready, 4'hF);
        chk("clr mem_addr", mem_addr, 0);
        chk("clr mem_src", mem_src, 0);
        repeat (3) begin
            cyc();
            chk("clr idle we", mem_we, 0);
        end
        in_valid = 4'b1001; in_addr = 64'h0703_0000_0000_0700; in_data = 64'h0BBB_0000_0000_0AAA;
        cyc();
        in_valid = 0;
        cyc();
        chk("clr rr_ptr0 src", mem_src, 0);
        chk("clr rr_ptr0 data", mem_wdata, 16'h0AAA);

        reset_dut("rand");
        for (int c = 0; c < 1500; c++) begin
            if (c == 700) reset_dut("mid");
            in_valid = 4'($urandom);
            for (int i = 0; i < 4; i++) begin
                in_addr[i*16 +: 16] = 16'($urandom);
                in_data[i*16 +: 16] = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            end
            mem_ready = ($urandom_range(0, 3) != 0);
            clear = ($urandom_range(0, 96) == 0);
            cyc();
        end
        clear = 0; in_valid = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
